// File: rtl/ram256_arbiter.sv
// Two-port arbiter in front of a single 256x32 synchronous RAM with byte enables.
// Each granted transaction runs IDLE -> ACCESS -> CAPTURE -> RESP and returns the RAM word to its owner.
module ram256_arbiter #(
   parameter int FIXED_PRIO = 0
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_A,
   input  logic [3:0]  WE_A,
   input  logic [7:0]  ADR_A,
   input  logic [31:0] DAT_I_A,
   output logic [31:0] DAT_O_A,
   output logic        ACK_A,
   input  logic        REQ_B,
   input  logic [3:0]  WE_B,
   input  logic [7:0]  ADR_B,
   input  logic [31:0] DAT_I_B,
   output logic [31:0] DAT_O_B,
   output logic        ACK_B,
   output logic        EN0,
   output logic [7:0]  A0,
   output logic [31:0] Di0,
   output logic [3:0]  WE0,
   input  logic [31:0] Do0,
   output logic        BUSY
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t      state_q, state_d;
   logic        grant;
   logic        winnerB;
   logic        ownerB_q;
   logic        lastB_q;
   logic [3:0]  we_q;
   logic [7:0]  adr_q;
   logic [31:0] di_q;
   logic [31:0] datA_q;
   logic [31:0] datB_q;

   // State register; reset lands in IDLE so the RAM strobes drop immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (REQ_A || REQ_B) state_d = ACCESS;
         ACCESS:  state_d = CAPTURE;
         CAPTURE: state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // With both requesting in round-robin mode the port not served last wins;
   // otherwise B wins only when A is not asking.
   always_comb begin
      grant   = (state_q == IDLE) && (REQ_A || REQ_B);
      winnerB = !REQ_A;
      if (FIXED_PRIO == 0 && REQ_A && REQ_B) begin
         winnerB = !lastB_q;
      end
   end

   // Request fields are latched only on grant, so requesters may change them freely afterwards.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ownerB_q <= 1'b0;
         lastB_q  <= 1'b1;
         we_q     <= 4'h0;
         adr_q    <= 8'h00;
         di_q     <= 32'h0;
         datA_q   <= 32'h0;
         datB_q   <= 32'h0;
      end else begin
         if (grant) begin
            ownerB_q <= winnerB;
            lastB_q  <= winnerB;
            we_q     <= winnerB ? WE_B    : WE_A;
            adr_q    <= winnerB ? ADR_B   : ADR_A;
            di_q     <= winnerB ? DAT_I_B : DAT_I_A;
         end
         if (state_q == CAPTURE) begin
            if (ownerB_q) begin
               datB_q <= Do0;
            end else begin
               datA_q <= Do0;
            end
         end
      end
   end

   // RAM strobes are decoded from state so a reset in ACCESS kills the write before the next edge.
   always_comb begin
      EN0   = 1'b0;
      A0    = 8'h00;
      Di0   = 32'h0;
      WE0   = 4'h0;
      ACK_A = 1'b0;
      ACK_B = 1'b0;
      BUSY  = (state_q != IDLE);
      case (state_q)
         ACCESS: begin
            EN0 = 1'b1;
            A0  = adr_q;
            Di0 = di_q;
            WE0 = we_q;
         end
         RESP: begin
            ACK_A = !ownerB_q;
            ACK_B = ownerB_q;
         end
         default: ;
      endcase
   end

   assign DAT_O_A = datA_q;
   assign DAT_O_B = datB_q;

endmodule

// File: tb/tb_ram256_arbiter.sv
// Bench for ram256_arbiter: a round-robin and a fixed-priority instance share the requester
// inputs, each with its own write-first RAM; a word-level model predicts grants and read data.
module tb_ram256_arbiter;

   logic        CLK;
   logic        RST;
   logic        reqA, reqB;
   logic [3:0]  weA, weB;
   logic [7:0]  adrA, adrB;
   logic [31:0] datInA, datInB;

   logic [31:0] datOutA0, datOutB0, datOutA1, datOutB1;
   logic        ackA0, ackB0, ackA1, ackB1;
   logic        ramEn0, ramEn1, busy0, busy1;
   logic [7:0]  ramAdr0, ramAdr1;
   logic [31:0] ramDi0, ramDi1;
   logic [3:0]  ramWe0, ramWe1;
   logic [31:0] ramDo0 = 32'h0;
   logic [31:0] ramDo1 = 32'h0;

   logic [31:0] mem0 [256] = '{default: 32'h0};
   logic [31:0] mem1 [256] = '{default: 32'h0};
   logic [31:0] w0, w1;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] refMem [256] = '{default: 32'h0};
   logic [31:0] lastDat [2];
   logic        modelLastB;

   typedef struct {
      logic        reqA;
      logic        reqB;
      logic [3:0]  weA;
      logic [7:0]  adrA;
      logic [31:0] datA;
      logic [3:0]  weB;
      logic [7:0]  adrB;
      logic [31:0] datB;
      logic        expB;
      logic [31:0] expData;
   } vec_t;

   vec_t vecs [8];

   ram256_arbiter #(.FIXED_PRIO(0)) dut0 (
      .CLK(CLK), .RST(RST),
      .REQ_A(reqA), .WE_A(weA), .ADR_A(adrA), .DAT_I_A(datInA), .DAT_O_A(datOutA0), .ACK_A(ackA0),
      .REQ_B(reqB), .WE_B(weB), .ADR_B(adrB), .DAT_I_B(datInB), .DAT_O_B(datOutB0), .ACK_B(ackB0),
      .EN0(ramEn0), .A0(ramAdr0), .Di0(ramDi0), .WE0(ramWe0), .Do0(ramDo0), .BUSY(busy0)
   );

   ram256_arbiter #(.FIXED_PRIO(1)) dut1 (
      .CLK(CLK), .RST(RST),
      .REQ_A(reqA), .WE_A(weA), .ADR_A(adrA), .DAT_I_A(datInA), .DAT_O_A(datOutA1), .ACK_A(ackA1),
      .REQ_B(reqB), .WE_B(weB), .ADR_B(adrB), .DAT_I_B(datInB), .DAT_O_B(datOutB1), .ACK_B(ackB1),
      .EN0(ramEn1), .A0(ramAdr1), .Di0(ramDi1), .WE0(ramWe1), .Do0(ramDo1), .BUSY(busy1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Write-first RAMs: read data is the post-write word one cycle after the address.
   always @(posedge CLK) begin
      if (ramEn0) begin
         w0 = mem0[ramAdr0];
         for (int b = 0; b < 4; b++) if (ramWe0[b]) w0[8*b +: 8] = ramDi0[8*b +: 8];
         mem0[ramAdr0] <= w0;
         ramDo0 <= w0;
      end
      if (ramEn1) begin
         w1 = mem1[ramAdr1];
         for (int b = 0; b < 4; b++) if (ramWe1[b]) w1[8*b +: 8] = ramDi1[8*b +: 8];
         mem1[ramAdr1] <= w1;
         ramDo1 <= w1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rA, input logic rB,
                                input logic [3:0] wA, input logic [7:0] aA, input logic [31:0] dA,
                                input logic [3:0] wB, input logic [7:0] aB, input logic [31:0] dB);
      reqA = rA; weA = wA; adrA = aA; datInA = dA;
      reqB = rB; weB = wB; adrB = aB; datInB = dB;
   endtask

   task automatic modelReset();
      modelLastB = 1'b1;
      lastDat[0] = 32'h0;
      lastDat[1] = 32'h0;
   endtask

   // Word-level RAM model: returns the word as it stands after applying the byte writes.
   task automatic modelTxn(input logic [3:0] we, input logic [7:0] adr, input logic [31:0] dat,
                           output logic [31:0] res);
      res = refMem[adr];
      for (int b = 0; b < 4; b++) if (we[b]) res[8*b +: 8] = dat[8*b +: 8];
      refMem[adr] = res;
   endtask

   task automatic runTxn(input string name, input logic expB, input logic [7:0] expAdr,
                         input logic [3:0] expWe, input logic [31:0] expDi, input logic [31:0] expData,
                         input bit glitch, input bit chk1, input logic exp1B);
      for (int k = 1; k <= 4; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (k == 1) begin
            checkOutput({name, ".busy"}, {31'h0, busy0}, 32'h1);
            checkOutput({name, ".en0"}, {31'h0, ramEn0}, 32'h1);
            checkOutput({name, ".a0"}, {24'h0, ramAdr0}, {24'h0, expAdr});
            checkOutput({name, ".we0"}, {28'h0, ramWe0}, {28'h0, expWe});
            checkOutput({name, ".di0"}, ramDi0, expDi);
         end
         if (k == 2) begin
            checkOutput({name, ".capIdle"}, {ramEn0, ramWe0, ramAdr0}, 32'h0);
            if (glitch) applyStimulus(1'b0, 1'b0, 4'hF, expAdr + 8'h1, 32'hFFFF_FFFF, 4'hF, 8'h99, 32'h5555_5555);
         end
         if (k == 3) begin
            checkOutput({name, ".ackA"}, {31'h0, ackA0}, {31'h0, !expB});
            checkOutput({name, ".ackB"}, {31'h0, ackB0}, {31'h0, expB});
            if (expB) begin
               checkOutput({name, ".datB"}, datOutB0, expData);
               checkOutput({name, ".holdA"}, datOutA0, lastDat[0]);
               lastDat[1] = expData;
            end else begin
               checkOutput({name, ".datA"}, datOutA0, expData);
               checkOutput({name, ".holdB"}, datOutB0, lastDat[1]);
               lastDat[0] = expData;
            end
            if (chk1) begin
               checkOutput({name, ".prioAckA"}, {31'h0, ackA1}, {31'h0, !exp1B});
               checkOutput({name, ".prioAckB"}, {31'h0, ackB1}, {31'h0, exp1B});
            end
         end
         if (k == 4) begin
            checkOutput({name, ".done"}, {30'h0, ackA0, ackB0}, 32'h0);
            checkOutput({name, ".idle"}, {31'h0, busy0}, 32'h0);
         end
      end
   endtask

   // Decides the winner from the arbitration rules and the current requester inputs.
   task automatic serveModel(input string name, input bit glitch, input bit chk1, input logic exp1B);
      logic        winB;
      logic [31:0] e;
      winB = (reqA && reqB) ? !modelLastB : reqB;
      modelLastB = winB;
      if (winB) begin
         modelTxn(weB, adrB, datInB, e);
         runTxn(name, 1'b1, adrB, weB, datInB, e, glitch, chk1, exp1B);
      end else begin
         modelTxn(weA, adrA, datInA, e);
         runTxn(name, 1'b0, adrA, weA, datInA, e, glitch, chk1, exp1B);
      end
   endtask

   task automatic doReset();
      RST = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      modelReset();
   endtask

   initial begin
      vec_t        v;
      logic [31:0] scratch;

      vecs[0] = '{1'b1, 1'b0, 4'hF, 8'h10, 32'hDEADBEEF, 4'h0, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF};
      vecs[1] = '{1'b1, 1'b0, 4'h0, 8'h10, 32'h0,        4'h0, 8'h00, 32'h0,        1'b0, 32'hDEADBEEF};
      vecs[2] = '{1'b0, 1'b1, 4'h0, 8'h00, 32'h0,        4'h2, 8'h10, 32'h0000AA00, 1'b1, 32'hDEADAAEF};
      vecs[3] = '{1'b1, 1'b1, 4'h0, 8'h10, 32'h0,        4'h0, 8'h20, 32'h0,        1'b0, 32'hDEADAAEF};
      vecs[4] = '{1'b1, 1'b1, 4'h0, 8'h10, 32'h0,        4'h3, 8'h20, 32'h00001234, 1'b1, 32'h00001234};
      vecs[5] = '{1'b1, 1'b0, 4'hC, 8'h20, 32'hABCD0000, 4'h0, 8'h00, 32'h0,        1'b0, 32'hABCD1234};
      vecs[6] = '{1'b1, 1'b1, 4'h0, 8'h20, 32'h0,        4'h0, 8'h20, 32'h0,        1'b1, 32'hABCD1234};
      vecs[7] = '{1'b1, 1'b1, 4'h1, 8'hFF, 32'h000000C3, 4'h0, 8'h10, 32'h0,        1'b0, 32'h000000C3};

      RST = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      modelReset();
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("reset.ram0", {ramEn0, ramWe0, ramAdr0}, 32'h0);
      checkOutput("reset.di0", ramDi0, 32'h0);
      checkOutput("reset.ctl0", {29'h0, ackA0, ackB0, busy0}, 32'h0);
      checkOutput("reset.datA0", datOutA0, 32'h0);
      checkOutput("reset.datB0", datOutB0, 32'h0);
      checkOutput("reset.ctl1", {28'h0, ackA1, ackB1, busy1, ramEn1}, 32'h0);
      RST = 1'b0;

      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         applyStimulus(v.reqA, v.reqB, v.weA, v.adrA, v.datA, v.weB, v.adrB, v.datB);
         if (v.expB) modelTxn(v.weB, v.adrB, v.datB, scratch);
         else        modelTxn(v.weA, v.adrA, v.datA, scratch);
         modelLastB = v.expB;
         runTxn($sformatf("vec%0d", i), v.expB, v.expB ? v.adrB : v.adrA, v.expB ? v.weB : v.weA,
                v.expB ? v.datB : v.datA, v.expData, 1'b0, 1'b0, 1'b0);
      end

      // Both ports hammering: round-robin alternates, fixed priority serves only A until A lets go.
      doReset();
      applyStimulus(1, 1, 4'h0, 8'h10, 32'h0, 4'h0, 8'h20, 32'h0);
      for (int t = 0; t < 4; t++) serveModel($sformatf("rr%0d", t), 1'b0, 1'b1, 1'b0);
      reqA = 1'b0;
      serveModel("rrOnlyB", 1'b0, 1'b1, 1'b1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset in the middle of a write access must abort it without touching the RAM.
      applyStimulus(1, 0, 4'hF, 8'h20, 32'h12345678, 4'h0, 8'h00, 32'h0);
      @(posedge CLK);
      @(negedge CLK);
      checkOutput("rstAcc.we0Pre", {28'h0, ramWe0}, 32'hF);
      RST = 1'b1;
      #1;
      checkOutput("rstAcc.we0", {28'h0, ramWe0}, 32'h0);
      checkOutput("rstAcc.en0busy", {30'h0, ramEn0, busy0}, 32'h0);
      checkOutput("rstAcc.datA", datOutA0, 32'h0);
      checkOutput("rstAcc.datB", datOutB0, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      RST = 1'b0;
      modelReset();
      for (int k = 0; k < 4; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         checkOutput($sformatf("rstAcc.quiet%0d", k), {29'h0, ackA0, ackB0, busy0}, 32'h0);
      end
      applyStimulus(1, 0, 4'h0, 8'h20, 32'h0, 4'h0, 8'h00, 32'h0);
      serveModel("rstAcc.read", 1'b0, 1'b0, 1'b0);

      // Fields scrambled and request dropped during CAPTURE must not alter the transaction.
      applyStimulus(1, 0, 4'hF, 8'h30, 32'h11112222, 4'h0, 8'h00, 32'h0);
      serveModel("capChg", 1'b1, 1'b0, 1'b0);
      applyStimulus(1, 0, 4'h0, 8'h31, 32'h0, 4'h0, 8'h00, 32'h0);
      serveModel("capChg.rd31", 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1, 4'h0, 8'h00, 32'h0, 4'h0, 8'h30, 32'h0);
      serveModel("capChg.rd30", 1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 40; r++) begin
         applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                       8'h40 + 8'($urandom_range(0, 7)), $urandom,
                       ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0,
                       8'h40 + 8'($urandom_range(0, 7)), $urandom);
         if (reqA || reqB) begin
            serveModel($sformatf("rnd%0d", r), 1'b0, 1'b0, 1'b0);
         end else begin
            @(posedge CLK);
            @(negedge CLK);
            checkOutput($sformatf("rnd%0d.noReq", r), {30'h0, busy0, ramEn0}, 32'h0);
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram256_arbiter.md
RAM256_ARBITER -- requirements
Module: ram256_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0, meaning 0 = round-robin between ports A and B, 1 = port A always wins.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port REQ_A  input  1  port A access request, level.
REQ-005 SHALL have port WE_A  input  4  port A byte write enables; 0 = read.
REQ-006 SHALL have port ADR_A  input  8  port A word address.
REQ-007 SHALL have port DAT_I_A  input  32  port A write data.
REQ-008 SHALL have port DAT_O_A  output  32  port A read data, valid while ACK_A=1.
REQ-009 SHALL have port ACK_A  output  1  port A one-cycle completion pulse.
REQ-010 SHALL have ports REQ_B, WE_B, ADR_B, DAT_I_B, DAT_O_B, ACK_B, identical to REQ-004..009 for port B.
REQ-011 SHALL have port EN0  output  1  RAM enable.
REQ-012 SHALL have port A0  output  8  RAM address.
REQ-013 SHALL have port Di0  output  32  RAM write data.
REQ-014 SHALL have port WE0  output  4  RAM byte write enables.
REQ-015 SHALL have port Do0  input  32  RAM read data, valid the cycle after the address is sampled.
REQ-016 SHALL have port BUSY  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> CAPTURE -> RESP -> IDLE; every transaction takes exactly 4 cycles, IDLE to IDLE.
REQ-018 IDLE: if REQ_A or REQ_B is sampled high, SHALL select a winner, register its WE/ADR/DAT_I into EN0=1/WE0/A0/Di0, record the owner, and go to ACCESS; otherwise remain in IDLE.
REQ-019 ACCESS: RAM outputs SHALL hold the registered values for exactly this cycle; unconditional transition to CAPTURE.
REQ-020 CAPTURE: EN0, WE0, A0 and Di0 SHALL be 0; Do0 SHALL be registered into the owner's DAT_O at the end of the cycle; transition to RESP.
REQ-021 RESP: the owner's ACK SHALL be high for exactly this one cycle, the other ACK low; transition to IDLE.
REQ-022 Outside ACCESS, EN0=0, WE0=4'h0, A0=8'h00 and Di0=32'h0 SHALL hold.
REQ-023 Write transactions SHALL also return data: DAT_O holds the post-write word, with unwritten bytes unchanged.
REQ-024 Round-robin (FIXED_PRIO=0): on simultaneous requests, the port not granted last SHALL win; a single requester always wins; the last-grant pointer SHALL update only on grant.
REQ-025 FIXED_PRIO=1: A SHALL win every simultaneous request; B is served only when REQ_A=0 in IDLE.
REQ-026 Requesters SHALL hold REQ and request fields stable until ACK; fields SHALL be sampled only in IDLE; changes during ACCESS/CAPTURE/RESP SHALL have no effect.
REQ-027 REQ still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-028 A REQ dropped before IDLE sampling SHALL produce no transaction; the arbiter SHALL NOT abort an already-granted transaction.
REQ-029 DAT_O_x SHALL hold its last captured value until that port's next CAPTURE.

Reset
REQ-030 Assertion of RST SHALL immediately, without waiting for CLK, force state IDLE, EN0=0, WE0=0, A0=0, Di0=0, ACK_A=ACK_B=0, BUSY=0, DAT_O_A=DAT_O_B=0, and set the last-grant pointer to B, so A wins first.
REQ-031 RST asserted during ACCESS SHALL force WE0=0 before the next edge, so no RAM write occurs; the transaction is dropped with no ACK.
REQ-032 After RST deasserts, the first IDLE sampling SHALL occur on the first rising CLK edge.

Verification
REQ-033 A write ADR_A=8'h10, WE_A=4'hF, DAT_I_A=32'hDEADBEEF, then a read of 8'h10 -> ACK_A on cycle 4 of each transaction; read DAT_O_A=32'hDEADBEEF.
REQ-034 Partial write WE_B=4'h2, DAT_I_B=32'h0000AA00 to address 8'h10 holding 32'hDEADBEEF -> DAT_O_B=32'hDEADAAEF in the ACK_B cycle.
REQ-035 REQ_A and REQ_B held high continuously, FIXED_PRIO=0 -> grants A,B,A,B, ACKs 4 cycles apart, never both high in one cycle.
REQ-036 Same stimulus with FIXED_PRIO=1 -> only ACK_A pulses; B served after REQ_A drops.
REQ-037 RST pulsed during ACCESS of a write to 8'h20, WE_A=4'hF, DAT_I_A=32'h12345678 -> no ACK; a later read of 8'h20 returns the prior contents.
REQ-038 Request fields changed during CAPTURE -> RAM access and DAT_O reflect only the values sampled in IDLE.
